// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 state encoding, sizes and GF(2^8) helpers
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_state_e;
  localparam int AES_NR = 10;
  localparam int AES_BLK = 128;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < AES_NR; i++) r = (i < int'(rnd)) ? xtime(r) : r;
    return r;
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3, xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0,
            xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1, xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
  endfunction
endpackage

// File: rtl/aes_final_round.sv
// aes_final_round: last AES round, SubBytes and ShiftRows with no MixColumns
module aes_final_round
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] state_in,
  input  logic [AES_BLK-1:0] key_in,
  output logic [AES_BLK-1:0] key_out,
  output logic [AES_BLK-1:0] round_out
);
  logic [AES_BLK-1:0] sb, sr;
  key_gen u_kg (.round_num(4'(AES_NR)), .key_in(key_in), .key_out(key_out));
  sub_bytes u_sb (.data_in(state_in), .data_out(sb));
  shift_rows u_sr (.data_in(sb), .data_out(sr));
  assign round_out = sr ^ key_out;
endmodule

// File: rtl/key_gen.sv
// key_gen: one AES-128 key-expansion step, rcon selected by round_num
module key_gen
  import aes_pkg::*;
(
  input  logic [3:0]         round_num,
  input  logic [AES_BLK-1:0] key_in,
  output logic [AES_BLK-1:0] key_out
);
  logic [31:0] rot, t, k0, k1, k2, k3;
  assign rot = {key_in[23:0], key_in[31:24]};
  assign t = {sbox(rot[31:24]) ^ rcon(round_num), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign k0 = key_in[127:96] ^ t;
  assign k1 = key_in[95:64] ^ k0;
  assign k2 = key_in[63:32] ^ k1;
  assign k3 = key_in[31:0] ^ k2;
  assign key_out = {k0, k1, k2, k3};
endmodule

// File: rtl/round.sv
// round: full AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) with its key step
module round
  import aes_pkg::*;
(
  input  logic [3:0]         round_num,
  input  logic [AES_BLK-1:0] data_in,
  input  logic [AES_BLK-1:0] key_in,
  output logic [AES_BLK-1:0] round_out,
  output logic [AES_BLK-1:0] key_out
);
  logic [AES_BLK-1:0] sb, sr, mc;
  sub_bytes u_sb (.data_in(data_in), .data_out(sb));
  shift_rows u_sr (.data_in(sb), .data_out(sr));
  key_gen u_kg (.round_num(round_num), .key_in(key_in), .key_out(key_out));
  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign mc[AES_BLK-1-32*c -: 32] = mix_col(sr[AES_BLK-1-32*c -: 32]);
  end
  assign round_out = mc ^ key_out;
endmodule

// File: rtl/shift_rows.sv
// shift_rows: row r rotated left by r bytes, column-major byte order
module shift_rows
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data_in,
  output logic [AES_BLK-1:0] data_out
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign data_out[AES_BLK-1-8*(4*c+r) -: 8] = data_in[AES_BLK-1-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

// File: rtl/sub_bytes.sv
// sub_bytes: S-box substitution of all sixteen state bytes
module sub_bytes
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data_in,
  output logic [AES_BLK-1:0] data_out
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign data_out[8*i +: 8] = sbox(data_in[8*i +: 8]);
  end
endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryptor, one round per clock behind valid/ready
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AES_BLK-1:0] plaintext,
  input  logic [AES_BLK-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AES_BLK-1:0] ciphertext,
  output logic               busy
);
  if (NR != AES_NR) begin : g_nr_check
    $error("aes_enc_iter supports only NR=10 (AES-128)");
  end
  aes_state_e fsm;
  logic [3:0] rnd;
  logic [AES_BLK-1:0] state_q, rkey_q, round_out, key_out, final_out, final_key;
  round u_round (
    .round_num(rnd), .data_in(state_q), .key_in(rkey_q), .round_out(round_out), .key_out(key_out)
  );
  aes_final_round u_final (
    .state_in(state_q), .key_in(rkey_q), .key_out(final_key), .round_out(final_out)
  );
  // sequencer: accept, nine full rounds, final round, hold result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      rnd <= '0;
      state_q <= '0;
      rkey_q <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      ciphertext <= '0;
      busy <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready <= !(in_valid && in_ready);
          if (in_valid && in_ready) begin
            fsm <= ROUND;
            state_q <= plaintext ^ key;
            rkey_q <= key;
            rnd <= 4'd1;
            busy <= 1'b1;
          end
        end
        ROUND: begin
          state_q <= round_out;
          rkey_q <= key_out;
          rnd <= rnd + 4'd1;
          if (rnd == 4'(NR - 1)) fsm <= FINAL;
        end
        FINAL: begin
          state_q <= final_out;
          rkey_q <= final_key;
          ciphertext <= final_out;
          out_valid <= 1'b1;
          busy <= 1'b0;
          fsm <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            fsm <= IDLE;
            out_valid <= 1'b0;
            rnd <= '0;
            in_ready <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: directed FIPS-197 vectors, backpressure, busy-ignore, abort and random traffic
module tb_aes_enc_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext;
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R1_C  = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  logic [127:0] vec_pt[3];
  logic [127:0] vec_key[3];
  logic [127:0] vec_ct[3];

  always #5 clk = ~clk;

  aes_enc_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // called on a negedge; returns on the negedge after the accepting edge
  task automatic send(input logic [127:0] pt, input logic [127:0] k);
    int n;
    n = 0;
    in_valid = 1'b1;
    plaintext = pt;
    key = k;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 128'(n < 100), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    plaintext = '0;
    key = '0;
  endtask

  // counts edges until out_valid is seen
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", 128'(out_valid), 128'(1));
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_pt[0] = PT_B;  vec_key[0] = KEY_B; vec_ct[0] = CT_B;
    vec_pt[1] = PT_C;  vec_key[1] = KEY_C; vec_ct[1] = CT_C;
    vec_pt[2] = '0;    vec_key[2] = '0;    vec_ct[2] = CT_Z;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ciphertext", ciphertext, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 128'(in_ready), 128'(1));

    // App. B: out_valid appears ten edges after the accepting edge (eleven counting it)
    send(PT_B, KEY_B);
    check("b_busy", 128'(busy), 128'(1));
    check("b_in_ready_low", 128'(in_ready), 128'(0));
    wait_out(n);
    check("b_latency", 128'(n), 128'(10));
    check("b_ciphertext", ciphertext, CT_B);
    check("b_busy_done", 128'(busy), 128'(0));
    take();
    check("b_idle_in_ready", 128'(in_ready), 128'(1));
    check("b_idle_out_valid", 128'(out_valid), 128'(0));

    // App. C.1 with state probe after round 1
    send(PT_C, KEY_C);
    @(negedge clk);
    check("c_round1_state", dut.state_q, R1_C);
    wait_out(n);
    check("c_latency", 128'(n), 128'(9));
    check("c_ciphertext", ciphertext, CT_C);
    take();

    // backpressure: result held for 20 cycles
    send('0, '0);
    wait_out(n);
    for (int i = 0; i < 20; i++) begin
      check("bp_ciphertext", ciphertext, CT_Z);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    take();
    check("bp_release_in_ready", 128'(in_ready), 128'(1));
    check("bp_release_out_valid", 128'(out_valid), 128'(0));

    // second block offered throughout the first one
    send(PT_B, KEY_B);
    in_valid = 1'b1;
    plaintext = PT_C;
    key = KEY_C;
    n = 0;
    while (!out_valid && n < 100) begin
      check("ign_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
      n++;
    end
    check("ign_first_ct", ciphertext, CT_B);
    take();
    check("ign_idle_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    plaintext = '0;
    key = '0;
    check("ign_second_busy", 128'(busy), 128'(1));
    wait_out(n);
    check("ign_second_ct", ciphertext, CT_C);
    take();

    // abort at round 5
    send(PT_B, KEY_B);
    repeat (4) @(negedge clk);
    check("abort_rnd", 128'(dut.rnd), 128'(5));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 12; i++) begin
      check("abort_out_valid", 128'(out_valid), 128'(0));
      @(negedge clk);
    end
    send(PT_B, KEY_B);
    wait_out(n);
    check("abort_fresh_latency", 128'(n), 128'(10));
    check("abort_fresh_ct", ciphertext, CT_B);
    take();

    // random back-to-back traffic cycling through known vectors
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(vec_pt[i % 3], vec_key[i % 3]);
        end
      end
      begin
        int m;
        for (int j = 0; j < 200; j++) begin
          wait_out(m);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          check("rand_ciphertext", ciphertext, vec_ct[j % 3]);
          take();
        end
      end
    join
    @(negedge clk);
    check("rand_drained", 128'(out_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
